// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch / countdown-timer controller driven by debounced one-cycle button pulses.
// Stopwatch mode counts up and records laps; timer mode counts down from load_val.
module stopwatch_timer_ctrl #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned TICK_DIV  = 100,
    localparam int unsigned IDX_W    = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1,
    localparam int unsigned LC_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_ss,
    input  logic             pb_lap,
    input  logic             pb_mode,
    input  logic [CNT_W-1:0] load_val,
    input  logic [IDX_W-1:0] lap_rd_idx,
    output logic [CNT_W-1:0] count,
    output logic             mode,
    output logic [2:0]       state,
    output logic             running,
    output logic [LC_W-1:0]  lap_count,
    output logic             lap_full,
    output logic [CNT_W-1:0] lap_rd_data,
    output logic             timer_done,
    output logic             overflow
);

    localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0] CntMax    = '1;
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [PS_W-1:0]  PsLast    = PS_W'(TICK_DIV - 1);
    localparam logic [LC_W-1:0]  LapDepthC = LC_W'(LAP_DEPTH);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSwRun   = 3'd1,
        StSwStop  = 3'd2,
        StTmRun   = 3'd3,
        StTmPause = 3'd4,
        StTmDone  = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [LC_W-1:0]  lap_count_q, lap_count_d;
    logic [CNT_W-1:0] lap_q [LAP_DEPTH];
    logic [CNT_W-1:0] lap_d [LAP_DEPTH];
    logic             overflow_q, overflow_d;

    logic run_now;
    logic tick;
    logic full_now;
    logic lap_wr;
    logic lap_clr;

    assign run_now  = (state_q == StSwRun) || (state_q == StTmRun);
    assign tick     = run_now && (ps_q == PsLast);
    assign full_now = (lap_count_q == LapDepthC);

    // Mode FSM: pb_ss beats pb_lap beats pb_mode within a cycle.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_d     = mode_q;
        overflow_d = overflow_q;
        lap_wr     = 1'b0;
        lap_clr    = 1'b0;

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                if (pb_ss) begin
                    if (!mode_q) begin
                        state_d = StSwRun;
                    end else if (load_val != '0) begin
                        state_d = StTmRun;
                        count_d = load_val;
                    end
                end else if (!pb_lap && pb_mode) begin
                    mode_d = ~mode_q;
                end
            end
            StSwRun: begin
                if (tick) begin
                    if (count_q == CntMax) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (pb_ss) begin
                    state_d = StSwStop;
                end else if (pb_lap && !full_now) begin
                    lap_wr = 1'b1;
                end
            end
            StSwStop: begin
                if (pb_ss) begin
                    state_d = StSwRun;
                end else if (pb_lap) begin
                    state_d    = StIdle;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    lap_clr    = 1'b1;
                end
            end
            StTmRun: begin
                if (tick) begin
                    count_d = count_q - 1'b1;
                end
                // Reaching zero takes precedence over a pause request.
                if (tick && (count_q == CntOne)) begin
                    state_d = StTmDone;
                end else if (pb_ss) begin
                    state_d = StTmPause;
                end
            end
            StTmPause: begin
                if (pb_ss) begin
                    state_d = StTmRun;
                end else if (pb_lap) begin
                    state_d = StIdle;
                    count_d = '0;
                end
            end
            StTmDone: begin
                count_d = '0;
                if (pb_ss || pb_lap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                count_d = '0;
            end
        endcase
    end

    // Prescaler only advances while staying in a running state, so every (re)start begins at 0.
    always_comb begin
        ps_d = '0;
        if (run_now && (state_d == state_q)) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end
    end

    always_comb begin
        lap_count_d = lap_count_q;
        for (int i = 0; i < int'(LAP_DEPTH); i++) begin
            lap_d[i] = lap_q[i];
        end
        if (lap_clr) begin
            lap_count_d = '0;
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                lap_d[i] = '0;
            end
        end else if (lap_wr) begin
            lap_count_d = lap_count_q + 1'b1;
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                if (lap_count_q == LC_W'(i)) begin
                    lap_d[i] = count_q;
                end
            end
        end
    end

    always_comb begin
        lap_rd_data = '0;
        for (int i = 0; i < int'(LAP_DEPTH); i++) begin
            if ((lap_rd_idx == IDX_W'(i)) && (LC_W'(i) < lap_count_q)) begin
                lap_rd_data = lap_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            mode_q      <= 1'b0;
            ps_q        <= '0;
            lap_count_q <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                lap_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            ps_q        <= ps_d;
            lap_count_q <= lap_count_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                lap_q[i] <= lap_d[i];
            end
        end
    end

    assign count      = count_q;
    assign mode       = mode_q;
    assign state      = state_q;
    assign running    = run_now;
    assign lap_count  = lap_count_q;
    assign lap_full   = full_now;
    assign timer_done = (state_q == StTmDone);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Bench for stopwatch_timer_ctrl: two instances (slow 16-bit, fast 4-bit) share stimulus and
// are compared every cycle against a behavioural model; directed steps add fixed expectations.
module tb_stopwatch_timer_ctrl;

    localparam int A_DIV = 4;
    localparam int B_DIV = 1;

    localparam int SIdle    = 0;
    localparam int SSwRun   = 1;
    localparam int SSwStop  = 2;
    localparam int STmRun   = 3;
    localparam int STmPause = 4;
    localparam int STmDone  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pb_ss;
    logic        pb_lap;
    logic        pb_mode;
    logic [15:0] load_val;
    logic [1:0]  lap_rd_idx;

    logic [15:0] a_count;
    logic        a_mode;
    logic [2:0]  a_state;
    logic        a_running;
    logic [2:0]  a_lap_count;
    logic        a_lap_full;
    logic [15:0] a_lap_rd_data;
    logic        a_timer_done;
    logic        a_overflow;

    logic [3:0]  b_count;
    logic        b_mode;
    logic [2:0]  b_state;
    logic        b_running;
    logic [2:0]  b_lap_count;
    logic        b_lap_full;
    logic [3:0]  b_lap_rd_data;
    logic        b_timer_done;
    logic        b_overflow;

    stopwatch_timer_ctrl #(.CNT_W(16), .LAP_DEPTH(4), .TICK_DIV(A_DIV)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .pb_ss      (pb_ss),
        .pb_lap     (pb_lap),
        .pb_mode    (pb_mode),
        .load_val   (load_val),
        .lap_rd_idx (lap_rd_idx),
        .count      (a_count),
        .mode       (a_mode),
        .state      (a_state),
        .running    (a_running),
        .lap_count  (a_lap_count),
        .lap_full   (a_lap_full),
        .lap_rd_data(a_lap_rd_data),
        .timer_done (a_timer_done),
        .overflow   (a_overflow)
    );

    stopwatch_timer_ctrl #(.CNT_W(4), .LAP_DEPTH(4), .TICK_DIV(B_DIV)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .pb_ss      (pb_ss),
        .pb_lap     (pb_lap),
        .pb_mode    (pb_mode),
        .load_val   (load_val[3:0]),
        .lap_rd_idx (lap_rd_idx),
        .count      (b_count),
        .mode       (b_mode),
        .state      (b_state),
        .running    (b_running),
        .lap_count  (b_lap_count),
        .lap_full   (b_lap_full),
        .lap_rd_data(b_lap_rd_data),
        .timer_done (b_timer_done),
        .overflow   (b_overflow)
    );

    int nvec = 0;
    int nerr = 0;

    // Model state per instance (0 = dut_a, 1 = dut_b).
    int m_st   [2];
    int m_cnt  [2];
    int m_mode [2];
    int m_ps   [2];
    int m_ovf  [2];
    int m_lapn [2];
    int m_lap  [2][4];

    int exp_laps [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flag(input bit x);
        return x ? 32'd1 : 32'd0;
    endfunction

    function automatic int exp_rd(input int k);
        int i;
        i = int'(lap_rd_idx);
        return (i < m_lapn[k]) ? m_lap[k][i] : 0;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int mx;
            int dv;
            int ld;
            int ns;
            int nc;
            bit run;
            bit tk;
            mx  = (k == 0) ? 65535 : 15;
            dv  = (k == 0) ? A_DIV : B_DIV;
            ld  = int'(load_val) & mx;
            run = (m_st[k] == SSwRun) || (m_st[k] == STmRun);
            tk  = run && (m_ps[k] == dv - 1);
            ns  = m_st[k];
            nc  = m_cnt[k];
            if (rst) begin
                ns        = SIdle;
                nc        = 0;
                m_mode[k] = 0;
                m_ovf[k]  = 0;
                m_lapn[k] = 0;
                for (int j = 0; j < 4; j++) m_lap[k][j] = 0;
                m_ps[k]   = 0;
            end else begin
                case (m_st[k])
                    SIdle: begin
                        if (pb_ss) begin
                            if (m_mode[k] == 0) ns = SSwRun;
                            else if (ld != 0) begin
                                ns = STmRun;
                                nc = ld;
                            end
                        end else if (!pb_lap && pb_mode) begin
                            m_mode[k] = 1 - m_mode[k];
                        end
                    end
                    SSwRun: begin
                        if (tk) begin
                            if (m_cnt[k] == mx) m_ovf[k] = 1;
                            else nc = m_cnt[k] + 1;
                        end
                        if (pb_ss) ns = SSwStop;
                        else if (pb_lap && m_lapn[k] < 4) begin
                            m_lap[k][m_lapn[k]] = m_cnt[k];
                            m_lapn[k]++;
                        end
                    end
                    SSwStop: begin
                        if (pb_ss) ns = SSwRun;
                        else if (pb_lap) begin
                            ns        = SIdle;
                            nc        = 0;
                            m_ovf[k]  = 0;
                            m_lapn[k] = 0;
                            for (int j = 0; j < 4; j++) m_lap[k][j] = 0;
                        end
                    end
                    STmRun: begin
                        if (tk) nc = m_cnt[k] - 1;
                        if (tk && nc == 0) ns = STmDone;
                        else if (pb_ss) ns = STmPause;
                    end
                    STmPause: begin
                        if (pb_ss) ns = STmRun;
                        else if (pb_lap) begin
                            ns = SIdle;
                            nc = 0;
                        end
                    end
                    STmDone: begin
                        if (pb_ss || pb_lap) ns = SIdle;
                    end
                    default: ns = SIdle;
                endcase
                m_ps[k] = (run && ns == m_st[k]) ? (m_ps[k] + 1) % dv : 0;
            end
            m_st[k]  = ns;
            m_cnt[k] = nc;
        end
    endtask

    task automatic check_all();
        chk("a_state", 32'(a_state), m_st[0]);
        chk("a_count", 32'(a_count), m_cnt[0]);
        chk("a_mode", 32'(a_mode), m_mode[0]);
        chk("a_running", 32'(a_running), flag(m_st[0] == SSwRun || m_st[0] == STmRun));
        chk("a_lap_count", 32'(a_lap_count), m_lapn[0]);
        chk("a_lap_full", 32'(a_lap_full), flag(m_lapn[0] == 4));
        chk("a_lap_rd_data", 32'(a_lap_rd_data), exp_rd(0));
        chk("a_timer_done", 32'(a_timer_done), flag(m_st[0] == STmDone));
        chk("a_overflow", 32'(a_overflow), m_ovf[0]);
        chk("b_state", 32'(b_state), m_st[1]);
        chk("b_count", 32'(b_count), m_cnt[1]);
        chk("b_mode", 32'(b_mode), m_mode[1]);
        chk("b_running", 32'(b_running), flag(m_st[1] == SSwRun || m_st[1] == STmRun));
        chk("b_lap_count", 32'(b_lap_count), m_lapn[1]);
        chk("b_lap_full", 32'(b_lap_full), flag(m_lapn[1] == 4));
        chk("b_lap_rd_data", 32'(b_lap_rd_data), exp_rd(1));
        chk("b_timer_done", 32'(b_timer_done), flag(m_st[1] == STmDone));
        chk("b_overflow", 32'(b_overflow), m_ovf[1]);
    endtask

    // One clock: model consumes the current inputs, DUTs sample them on the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        pb_ss   = 1'b0;
        pb_lap  = 1'b0;
        pb_mode = 1'b0;
        check_all();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_st[k] = SIdle; m_cnt[k] = 0; m_mode[k] = 0; m_ps[k] = 0;
            m_ovf[k] = 0; m_lapn[k] = 0;
            for (int j = 0; j < 4; j++) m_lap[k][j] = 0;
        end
        exp_laps[0] = 3; exp_laps[1] = 7; exp_laps[2] = 9; exp_laps[3] = 12;
        rst = 1'b1; pb_ss = 1'b0; pb_lap = 1'b0; pb_mode = 1'b0;
        load_val = '0; lap_rd_idx = '0;

        cycle();
        chk("rst_state_a", 32'(a_state), 0);
        chk("rst_count_a", 32'(a_count), 0);
        chk("rst_running_a", 32'(a_running), 0);

        // Stopwatch counting, stop, and saturation of the 4-bit instance.
        pb_ss = 1'b1; cycle();
        chk("sw_state_c1_a", 32'(a_state), 1);
        chk("sw_state_c1_b", 32'(b_state), 1);
        repeat (4) cycle();
        chk("sw_count_c5_a", 32'(a_count), 1);
        repeat (11) cycle();
        chk("sat_count_c16_b", 32'(b_count), 15);
        chk("sat_ovf_c16_b", 32'(b_overflow), 0);
        cycle();
        chk("sat_ovf_c17_b", 32'(b_overflow), 1);
        repeat (24) cycle();
        chk("sw_count_c41_a", 32'(a_count), 10);
        chk("sat_count_c41_b", 32'(b_count), 15);
        pb_ss = 1'b1; cycle();
        chk("sw_stop_state_a", 32'(a_state), 2);
        repeat (10) cycle();
        chk("sw_frozen_a", 32'(a_count), 10);
        pb_lap = 1'b1; cycle();
        chk("sw_clear_state_a", 32'(a_state), 0);
        chk("sat_clear_ovf_b", 32'(b_overflow), 0);

        // Laps on the tick-every-cycle instance.
        pb_ss = 1'b1; cycle();
        for (int c = 0; c < 16; c++) begin
            pb_lap = (c == 3 || c == 7 || c == 9 || c == 12 || c == 15);
            cycle();
        end
        chk("lap_count_b", 32'(b_lap_count), 4);
        chk("lap_full_b", 32'(b_lap_full), 1);
        for (int i = 0; i < 4; i++) begin
            lap_rd_idx = 2'(i);
            #1;
            chk("lap_rd_b", 32'(b_lap_rd_data), exp_laps[i]);
        end
        pb_ss = 1'b1; cycle();
        pb_lap = 1'b1; cycle();
        chk("lap_clr_state_b", 32'(b_state), 0);
        chk("lap_clr_count_b", 32'(b_lap_count), 0);
        lap_rd_idx = 2'd0;
        #1;
        chk("lap_clr_rd_b", 32'(b_lap_rd_data), 0);

        // Timer countdown.
        pb_mode = 1'b1; cycle();
        chk("tm_mode_a", 32'(a_mode), 1);
        load_val = 16'd3; pb_ss = 1'b1; cycle();
        chk("tm_load_a", 32'(a_count), 3);
        chk("tm_state_a", 32'(a_state), 3);
        repeat (4) cycle();
        chk("tm_cnt2_a", 32'(a_count), 2);
        repeat (4) cycle();
        chk("tm_cnt1_a", 32'(a_count), 1);
        repeat (4) cycle();
        chk("tm_cnt0_a", 32'(a_count), 0);
        chk("tm_done_state_a", 32'(a_state), 5);
        chk("tm_done_flag_a", 32'(a_timer_done), 1);
        pb_lap = 1'b1; cycle();
        chk("tm_ack_state_a", 32'(a_state), 0);
        chk("tm_ack_done_a", 32'(a_timer_done), 0);
        chk("tm_ack_mode_a", 32'(a_mode), 1);

        load_val = 16'd0; pb_ss = 1'b1; cycle();
        chk("tm_zero_load_a", 32'(a_state), 0);
        chk("tm_zero_load_b", 32'(b_state), 0);

        // pb_ss on the terminal tick.
        load_val = 16'd2; pb_ss = 1'b1; cycle();
        repeat (7) cycle();
        chk("tm_pre_term_a", 32'(a_count), 1);
        pb_ss = 1'b1; cycle();
        chk("tm_term_wins_a", 32'(a_state), 5);
        chk("tm_term_count_a", 32'(a_count), 0);
        pb_ss = 1'b1; cycle();

        // Pause holds the count.
        load_val = 16'd5; pb_ss = 1'b1; cycle();
        repeat (12) cycle();
        chk("tm_cnt_before_pause_a", 32'(a_count), 2);
        pb_ss = 1'b1; cycle();
        chk("tm_pause_state_a", 32'(a_state), 4);
        repeat (20) cycle();
        chk("tm_pause_hold_a", 32'(a_count), 2);
        pb_ss = 1'b1; cycle();
        chk("tm_resume_a", 32'(a_state), 3);
        pb_lap = 1'b1; cycle();
        chk("tm_lap_ignored_a", 32'(a_state), 3);
        pb_ss = 1'b1; cycle();
        pb_lap = 1'b1; cycle();
        chk("tm_abort_state_a", 32'(a_state), 0);
        chk("tm_abort_count_a", 32'(a_count), 0);

        // Reset in the middle of a stopwatch run with laps stored.
        pb_mode = 1'b1; cycle();
        pb_ss = 1'b1; cycle();
        repeat (6) cycle();
        pb_lap = 1'b1; cycle();
        repeat (5) cycle();
        pb_lap = 1'b1; cycle();
        chk("mid_laps_a", 32'(a_lap_count), 2);
        rst = 1'b1; cycle();
        chk("mid_rst_state_a", 32'(a_state), 0);
        chk("mid_rst_count_a", 32'(a_count), 0);
        chk("mid_rst_laps_a", 32'(a_lap_count), 0);
        chk("mid_rst_mode_a", 32'(a_mode), 0);
        pb_ss = 1'b1; cycle();
        repeat (3) cycle();
        chk("mid_rst_ps_a", 32'(a_count), 0);
        cycle();
        chk("mid_rst_tick_a", 32'(a_count), 1);

        // Random pulses against the model.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            pb_ss      = ($urandom_range(0, 9) == 0);
            pb_lap     = ($urandom_range(0, 7) == 0);
            pb_mode    = ($urandom_range(0, 11) == 0);
            load_val   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 12));
            lap_rd_idx = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
